// File: rtl/rv32i_imem_arb_pkg.sv
// Shared types and widths for the instruction-memory port arbiter.
package rv32i_imem_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } arb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/rv32i_imem_arb_timeout.sv
// Access watchdog: counts cycles since the grant and flags the last allowed one.
module rv32i_imem_arb_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_en,
    output logic o_expired_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // The grant cycle itself counts as the first cycle of the budget.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (i_start) begin
            cnt <= CNT_W'(1);
        end else if (i_en && (cnt != LAST)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign o_expired_c = i_en && (cnt == LAST);

endmodule

// File: rtl/rv32i_imem_port_arbiter.sv
// Shares the single instruction-memory port between fetch reads and loader writes.
// Define IMEM_ARB_PERF_EN to build the o_perf_* completion counters.
module rv32i_imem_port_arbiter
    import rv32i_imem_arb_pkg::*;
#(
    parameter int unsigned MAX_LOAD_BURST = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_fetch_req,
    input  logic [ADDR_W-1:0] i_fetch_addr,
    output logic              o_fetch_gnt,
    output logic              o_fetch_valid,
    output logic [DATA_W-1:0] o_fetch_data,
    input  logic              i_flush,
    input  logic              i_load_req,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [DATA_W-1:0] i_load_data,
    output logic              o_load_gnt,
    output logic              o_load_done,
    output logic              o_err,
    output logic              o_busy,
    output logic              o_mem_rst,
    output logic              o_mem_rd_en,
    output logic [ADDR_W-1:0] o_mem_rd_addr,
    input  logic [DATA_W-1:0] i_mem_rd_data,
    input  logic              i_mem_rd_valid,
    output logic              o_mem_wr_en,
    output logic [ADDR_W-1:0] o_mem_wr_addr,
    output logic [DATA_W-1:0] o_mem_wr_data,
    input  logic              i_mem_wr_valid,
    output logic [31:0]       o_perf_rd_cnt,
    output logic [31:0]       o_perf_wr_cnt,
    output logic [31:0]       o_perf_kill_cnt
);

    localparam int unsigned BURST_W = 4;

    arb_state_e        state_q, state_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    wr_req_t           wr_q, wr_d;
    logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              load_done_q, load_done_d;
    logic              err_q, err_d;
    logic              mem_rst_q, mem_rst_d;
    logic              fetch_gnt_c, load_gnt_c, fetch_wins_c, expired_c;

    // Grants are decided combinationally in IDLE so the requester sees them in its request cycle.
    always_comb begin
        fetch_wins_c = i_fetch_req &&
                       (!i_load_req || (burst_q == BURST_W'(MAX_LOAD_BURST)));
        fetch_gnt_c  = 1'b0;
        load_gnt_c   = 1'b0;
        if ((state_q == IDLE) && !i_rst && !i_flush) begin
            fetch_gnt_c = fetch_wins_c;
            load_gnt_c  = i_load_req && !fetch_wins_c;
        end
    end

    rv32i_imem_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (fetch_gnt_c || load_gnt_c),
        .i_en       (state_q != IDLE),
        .o_expired_c(expired_c)
    );

    always_comb begin
        state_d       = state_q;
        rd_addr_d     = rd_addr_q;
        wr_d          = wr_q;
        fetch_data_d  = fetch_data_q;
        fetch_valid_d = 1'b0;
        load_done_d   = 1'b0;
        err_d         = 1'b0;
        mem_rst_d     = 1'b0;
        burst_d       = burst_q;

        case (state_q)
            IDLE: begin
                if (fetch_gnt_c) begin
                    state_d   = READ;
                    rd_addr_d = i_fetch_addr;
                end else if (load_gnt_c) begin
                    state_d   = WRITE;
                    wr_d.addr = i_load_addr;
                    wr_d.data = i_load_data;
                end
            end
            READ: begin
                // A flush beats a same-cycle read valid: the data is dropped.
                if (i_flush) begin
                    state_d   = IDLE;
                    mem_rst_d = 1'b1;
                end else if (i_mem_rd_valid) begin
                    state_d       = IDLE;
                    fetch_data_d  = i_mem_rd_data;
                    fetch_valid_d = 1'b1;
                end else if (expired_c) begin
                    state_d   = IDLE;
                    err_d     = 1'b1;
                    mem_rst_d = 1'b1;
                end
            end
            WRITE: begin
                if (i_mem_wr_valid) begin
                    state_d     = IDLE;
                    load_done_d = 1'b1;
                end else if (expired_c) begin
                    state_d   = IDLE;
                    err_d     = 1'b1;
                    mem_rst_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Load-burst fairness: only counts loads that overtook a waiting fetch.
        if (!i_fetch_req || fetch_gnt_c) begin
            burst_d = '0;
        end else if (load_gnt_c && (burst_q != '1)) begin
            burst_d = burst_q + BURST_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= IDLE;
            burst_q       <= '0;
            rd_addr_q     <= '0;
            wr_q          <= '0;
            fetch_data_q  <= '0;
            fetch_valid_q <= 1'b0;
            load_done_q   <= 1'b0;
            err_q         <= 1'b0;
            mem_rst_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            burst_q       <= burst_d;
            rd_addr_q     <= rd_addr_d;
            wr_q          <= wr_d;
            fetch_data_q  <= fetch_data_d;
            fetch_valid_q <= fetch_valid_d;
            load_done_q   <= load_done_d;
            err_q         <= err_d;
            mem_rst_q     <= mem_rst_d;
        end
    end

    assign o_fetch_gnt   = fetch_gnt_c;
    assign o_load_gnt    = load_gnt_c;
    assign o_fetch_valid = fetch_valid_q;
    assign o_fetch_data  = fetch_data_q;
    assign o_load_done   = load_done_q;
    assign o_err         = err_q;
    assign o_busy        = (state_q != IDLE);
    assign o_mem_rst     = i_rst || mem_rst_q;
    assign o_mem_rd_en   = (state_q == READ);
    assign o_mem_rd_addr = rd_addr_q;
    assign o_mem_wr_en   = (state_q == WRITE);
    assign o_mem_wr_addr = wr_q.addr;
    assign o_mem_wr_data = wr_q.data;

`ifdef IMEM_ARB_PERF_EN
    logic [31:0] perf_rd_q, perf_wr_q, perf_kill_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            perf_rd_q   <= '0;
            perf_wr_q   <= '0;
            perf_kill_q <= '0;
        end else begin
            if (fetch_valid_d) perf_rd_q <= sat_inc(perf_rd_q);
            if (load_done_d) perf_wr_q <= sat_inc(perf_wr_q);
            if ((state_q == READ) && i_flush) perf_kill_q <= sat_inc(perf_kill_q);
        end
    end

    assign o_perf_rd_cnt   = perf_rd_q;
    assign o_perf_wr_cnt   = perf_wr_q;
    assign o_perf_kill_cnt = perf_kill_q;
`else
    assign o_perf_rd_cnt   = '0;
    assign o_perf_wr_cnt   = '0;
    assign o_perf_kill_cnt = '0;
`endif

endmodule

// File: tb/tb_rv32i_imem_port_arbiter.sv
// Directed bench for rv32i_imem_port_arbiter (MAX_LOAD_BURST=4, TIMEOUT_CYCLES=8).
module tb_rv32i_imem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req, flush, load_req;
    logic [31:0] fetch_addr, load_addr, load_data;
    logic        fetch_gnt, fetch_valid, load_gnt, load_done, err, busy;
    logic [31:0] fetch_data;
    logic        mem_rst, mem_rd_en, mem_wr_en, mem_rd_valid, mem_wr_valid;
    logic [31:0] mem_rd_addr, mem_rd_data, mem_wr_addr, mem_wr_data;
    logic [31:0] perf_rd, perf_wr, perf_kill;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef IMEM_ARB_PERF_EN
    localparam logic [31:0] EXP_RD = 32'd3, EXP_WR = 32'd6, EXP_KILL = 32'd1;
`else
    localparam logic [31:0] EXP_RD = 32'd0, EXP_WR = 32'd0, EXP_KILL = 32'd0;
`endif

    rv32i_imem_port_arbiter #(
        .MAX_LOAD_BURST(4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_fetch_req    (fetch_req),
        .i_fetch_addr   (fetch_addr),
        .o_fetch_gnt    (fetch_gnt),
        .o_fetch_valid  (fetch_valid),
        .o_fetch_data   (fetch_data),
        .i_flush        (flush),
        .i_load_req     (load_req),
        .i_load_addr    (load_addr),
        .i_load_data    (load_data),
        .o_load_gnt     (load_gnt),
        .o_load_done    (load_done),
        .o_err          (err),
        .o_busy         (busy),
        .o_mem_rst      (mem_rst),
        .o_mem_rd_en    (mem_rd_en),
        .o_mem_rd_addr  (mem_rd_addr),
        .i_mem_rd_data  (mem_rd_data),
        .i_mem_rd_valid (mem_rd_valid),
        .o_mem_wr_en    (mem_wr_en),
        .o_mem_wr_addr  (mem_wr_addr),
        .o_mem_wr_data  (mem_wr_data),
        .i_mem_wr_valid (mem_wr_valid),
        .o_perf_rd_cnt  (perf_rd),
        .o_perf_wr_cnt  (perf_wr),
        .o_perf_kill_cnt(perf_kill)
    );

    always #5 clk = ~clk;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; fetch_req = 1'b0; flush = 1'b0; load_req = 1'b0;
        fetch_addr = '0; load_addr = '0; load_data = '0;
        mem_rd_data = '0; mem_rd_valid = 1'b0; mem_wr_valid = 1'b0;

        // Reset state
        nxt(); nxt(); #2;
        chk("rst_mem_rst", mem_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_err", err, 0);
        chk("rst_fetch_data", fetch_data, 0);
        chk("rst_perf_rd", perf_rd, 0);

        // Fetch 0x0, memory valid two cycles after grant
        nxt(); rst = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h0; #2;
        chk("s1_gnt_t0", fetch_gnt, 1);
        chk("s1_busy_t0", busy, 0);
        chk("s1_mem_rst_t0", mem_rst, 0);
        nxt(); fetch_req = 1'b0; fetch_addr = 32'hFFFF_FFFF; #2;
        chk("s1_busy_t1", busy, 1);
        chk("s1_gnt_t1", fetch_gnt, 0);
        chk("s1_rd_en_t1", mem_rd_en, 1);
        chk("s1_rd_addr_t1", mem_rd_addr, 32'h0);
        nxt(); mem_rd_valid = 1'b1; mem_rd_data = 32'hDEAD_BEEF; #2;
        chk("s1_busy_t2", busy, 1);
        chk("s1_valid_t2", fetch_valid, 0);
        nxt(); mem_rd_valid = 1'b0; mem_rd_data = '0; #2;
        chk("s1_valid_t3", fetch_valid, 1);
        chk("s1_data_t3", fetch_data, 32'hDEAD_BEEF);
        chk("s1_busy_t3", busy, 0);
        nxt(); #2;
        chk("s1_valid_t4", fetch_valid, 0);

        // Load burst of 4 while fetch waits, then fetch, then load again
        nxt(); fetch_req = 1'b1; load_req = 1'b1; fetch_addr = 32'h200;
        for (int k = 0; k < 4; k++) begin
            load_addr = 32'h100 + 32'(4 * k);
            load_data = 32'hA000_0000 + 32'(k);
            #2;
            chk("s2_load_gnt", load_gnt, 1);
            chk("s2_fetch_gnt_held", fetch_gnt, 0);
            if (k > 0) chk("s2_load_done", load_done, 1);
            nxt(); mem_wr_valid = 1'b1; #2;
            chk("s2_wr_en", mem_wr_en, 1);
            chk("s2_wr_addr", mem_wr_addr, 32'h100 + 32'(4 * k));
            chk("s2_wr_data", mem_wr_data, 32'hA000_0000 + 32'(k));
            nxt(); mem_wr_valid = 1'b0;
        end
        #2;
        chk("s2_fetch_gnt_fair", fetch_gnt, 1);
        chk("s2_load_gnt_blocked", load_gnt, 0);
        chk("s2_load_done_4", load_done, 1);
        nxt(); fetch_req = 1'b0; mem_rd_valid = 1'b1; mem_rd_data = 32'h1234_5678; #2;
        chk("s2_rd_addr", mem_rd_addr, 32'h200);
        nxt(); mem_rd_valid = 1'b0; load_addr = 32'h300; load_data = 32'h5555; #2;
        chk("s2_fetch_valid", fetch_valid, 1);
        chk("s2_fetch_data", fetch_data, 32'h1234_5678);
        chk("s2_load_gnt_after", load_gnt, 1);
        nxt(); load_req = 1'b0; mem_wr_valid = 1'b1; #2;
        chk("s2_wr_addr_5", mem_wr_addr, 32'h300);
        nxt(); mem_wr_valid = 1'b0; #2;
        chk("s2_load_done_5", load_done, 1);
        chk("s2_busy_end", busy, 0);

        // Flush arriving with rd_valid kills the read
        nxt(); fetch_req = 1'b1; fetch_addr = 32'h40; #2;
        chk("s3_gnt", fetch_gnt, 1);
        nxt(); fetch_req = 1'b0; #2;
        nxt(); mem_rd_valid = 1'b1; mem_rd_data = 32'hBAD0_BAD0; flush = 1'b1;
        fetch_req = 1'b1; fetch_addr = 32'h44; #2;
        chk("s3_gnt_in_read", fetch_gnt, 0);
        chk("s3_mem_rst_pre", mem_rst, 0);
        nxt(); mem_rd_valid = 1'b0; flush = 1'b0; #2;
        chk("s3_no_valid", fetch_valid, 0);
        chk("s3_mem_rst", mem_rst, 1);
        chk("s3_data_kept", fetch_data, 32'h1234_5678);
        chk("s3_regrant", fetch_gnt, 1);
        nxt(); fetch_req = 1'b0; mem_rd_valid = 1'b1; mem_rd_data = 32'h0BAD_F00D; #2;
        chk("s3_mem_rst_1cyc", mem_rst, 0);
        chk("s3_rd_addr", mem_rd_addr, 32'h44);
        nxt(); mem_rd_valid = 1'b0; #2;
        chk("s3_valid_2", fetch_valid, 1);
        chk("s3_data_2", fetch_data, 32'h0BAD_F00D);

        // Flush during WRITE is ignored; flush in IDLE blocks grants
        nxt(); load_req = 1'b1; load_addr = 32'h80; load_data = 32'hCAFE; #2;
        chk("s4_load_gnt", load_gnt, 1);
        nxt(); load_req = 1'b0; flush = 1'b1; #2;
        chk("s4_wr_en", mem_wr_en, 1);
        chk("s4_mem_rst_a", mem_rst, 0);
        nxt(); mem_wr_valid = 1'b1; #2;
        chk("s4_busy", busy, 1);
        chk("s4_mem_rst_b", mem_rst, 0);
        nxt(); mem_wr_valid = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h60; #2;
        chk("s4_load_done", load_done, 1);
        chk("s4_mem_rst_c", mem_rst, 0);
        chk("s4_flush_blocks_gnt", fetch_gnt, 0);
        nxt(); flush = 1'b0; #2;
        chk("s5_gnt", fetch_gnt, 1);

        // Memory never answers: o_err eight cycles after grant
        nxt(); fetch_req = 1'b0;
        for (int c = 0; c < 6; c++) nxt();
        #2;
        chk("s5_err_t7", err, 0);
        chk("s5_busy_t7", busy, 1);
        nxt(); fetch_req = 1'b1; fetch_addr = 32'h64; #2;
        chk("s5_err_t8", err, 1);
        chk("s5_mem_rst_t8", mem_rst, 1);
        chk("s5_busy_t8", busy, 0);
        chk("s5_no_valid", fetch_valid, 0);
        chk("s5_regrant", fetch_gnt, 1);
        nxt(); fetch_req = 1'b0; #2;
        chk("s5_err_t9", err, 0);
        chk("s5_rd_addr", mem_rd_addr, 32'h64);
        chk("perf_rd", perf_rd, EXP_RD);
        chk("perf_wr", perf_wr, EXP_WR);
        chk("perf_kill", perf_kill, EXP_KILL);

        // Reset in READ abandons the access
        nxt(); rst = 1'b1; #2;
        chk("s6_mem_rst_in_rst", mem_rst, 1);
        nxt(); rst = 1'b0; mem_rd_valid = 1'b1; mem_rd_data = 32'h7777; #2;
        chk("s6_busy", busy, 0);
        chk("s6_rd_en", mem_rd_en, 0);
        chk("s6_rd_addr", mem_rd_addr, 0);
        chk("s6_mem_rst", mem_rst, 0);
        chk("s6_perf_rd", perf_rd, 0);
        chk("s6_perf_wr", perf_wr, 0);
        chk("s6_perf_kill", perf_kill, 0);
        nxt(); mem_rd_valid = 1'b0; #2;
        chk("s6_no_valid", fetch_valid, 0);
        chk("s6_fetch_data", fetch_data, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
